// File: rtl/cia_cycle_sequencer.sv
// Sequences 68040 accesses to the two 8520 CIAs: E clock generation, E-aligned chip selects, TA request.
// Optional macro CIA_TIMEOUT_EN adds an access watchdog that ends stuck cycles with TEA_REQ.
module cia_cycle_sequencer #(
  parameter int unsigned E_LOW_TICKS    = 6,
  parameter int unsigned E_HIGH_TICKS   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic       CLK40,
  input  logic       nRESET,
  input  logic       CLK7,
  input  logic       TS,
  input  logic       CIA_SPACE,
  input  logic       RnW,
  input  logic [1:0] A,
  output logic       CLKCIA,
  output logic       nCIACS0,
  output logic       nCIACS1,
  output logic       TA_REQ,
  output logic       TEA_REQ,
  output logic       CIA_BUSY
);

  localparam int unsigned E_PERIOD = E_LOW_TICKS + E_HIGH_TICKS;
  localparam int unsigned E_W      = (E_PERIOD > 1) ? $clog2(E_PERIOD) : 1;
  localparam logic [E_W-1:0] E_LAST       = E_W'(E_PERIOD - 1);
  localparam logic [E_W-1:0] E_HIGH_START = E_W'(E_LOW_TICKS);

  typedef enum logic [1:0] {IDLE, ARM, STROBE, DONE} state_t;

  state_t         state, state_next;
  logic [2:0]     sync_q;
  logic [E_W-1:0] ecnt, ecnt_next;
  logic           tick, ewrap;
  logic           cs0_q, cs1_q, cs0_next, cs1_next;
  logic           ncs0_next, ncs1_next, ta_next;
  logic           wd_expired;

  // Read and write cycles share identical timing, so RnW is deliberately ignored.
  logic unused_rnw;
  assign unused_rnw = RnW;

  assign tick  = sync_q[1] & ~sync_q[2];
  assign ewrap = tick & (ecnt == E_LAST);

  // Free-running E period counter; CLKCIA follows the next count so it changes on the tick edge.
  always_comb begin
    ecnt_next = ecnt;
    if (tick) begin
      ecnt_next = (ecnt == E_LAST) ? '0 : ecnt + E_W'(1);
    end
  end

  always_ff @(posedge CLK40) begin
    if (!nRESET) begin
      sync_q <= '0;
      ecnt   <= '0;
      CLKCIA <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], CLK7};
      ecnt   <= ecnt_next;
      CLKCIA <= (ecnt_next >= E_HIGH_START);
    end
  end

`ifdef CIA_TIMEOUT_EN
  localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES) > 11) ? $clog2(TIMEOUT_CYCLES) : 11;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog;
  logic            tea_next;

  assign wd_expired = (wdog == WD_LAST);

  // Watchdog runs only while an access waits on the E clock.
  always_ff @(posedge CLK40) begin
    if (!nRESET) begin
      wdog    <= '0;
      TEA_REQ <= 1'b0;
    end else begin
      wdog    <= (state == ARM || state == STROBE) ? wdog + WD_W'(1) : '0;
      TEA_REQ <= tea_next;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
  assign TEA_REQ        = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_next = state;
    cs0_next   = cs0_q;
    cs1_next   = cs1_q;
    ncs0_next  = nCIACS0;
    ncs1_next  = nCIACS1;
    ta_next    = 1'b0;
`ifdef CIA_TIMEOUT_EN
    tea_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (TS && CIA_SPACE && !TA_REQ) begin
          state_next = ARM;
          cs0_next   = ~A[0];
          cs1_next   = ~A[1];
        end
      end
      ARM: begin
        if (ewrap) begin
          state_next = STROBE;
          ncs0_next  = ~cs0_q;
          ncs1_next  = ~cs1_q;
        end
`ifdef CIA_TIMEOUT_EN
        else if (wd_expired) begin
          state_next = DONE;
          tea_next   = 1'b1;
          ncs0_next  = 1'b1;
          ncs1_next  = 1'b1;
        end
`endif
      end
      STROBE: begin
        if (ewrap) begin
          state_next = DONE;
          ta_next    = 1'b1;
          ncs0_next  = 1'b1;
          ncs1_next  = 1'b1;
        end
`ifdef CIA_TIMEOUT_EN
        else if (wd_expired) begin
          state_next = DONE;
          tea_next   = 1'b1;
          ncs0_next  = 1'b1;
          ncs1_next  = 1'b1;
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (!nRESET) begin
      state    <= IDLE;
      cs0_q    <= 1'b0;
      cs1_q    <= 1'b0;
      nCIACS0  <= 1'b1;
      nCIACS1  <= 1'b1;
      TA_REQ   <= 1'b0;
      CIA_BUSY <= 1'b0;
    end else begin
      state    <= state_next;
      cs0_q    <= cs0_next;
      cs1_q    <= cs1_next;
      nCIACS0  <= ncs0_next;
      nCIACS1  <= ncs1_next;
      TA_REQ   <= ta_next;
      CIA_BUSY <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_cia_cycle_sequencer.sv
// Directed bench for cia_cycle_sequencer: E clock shape, CIA access timing, reset and abort cases.
// Define CIA_TIMEOUT_EN on both files to exercise the watchdog variant.
module tb_cia_cycle_sequencer;

`ifdef CIA_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 64;
`else
  localparam int unsigned TB_TIMEOUT = 2048;
`endif

  logic       CLK40, nRESET, CLK7, TS, CIA_SPACE, RnW;
  logic [1:0] A;
  logic       CLKCIA, nCIACS0, nCIACS1, TA_REQ, TEA_REQ, CIA_BUSY;
  logic       clk7_run;
  int         c7cnt;
  int         n_checks, n_pass, n_fail;

  typedef struct {
    int e_falls;
    int len0;
    int len1;
    int ta_pulses;
  } exp_t;
  exp_t sb[$];

  cia_cycle_sequencer #(
    .E_LOW_TICKS   (6),
    .E_HIGH_TICKS  (4),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .CLK40    (CLK40),
    .nRESET   (nRESET),
    .CLK7     (CLK7),
    .TS       (TS),
    .CIA_SPACE(CIA_SPACE),
    .RnW      (RnW),
    .A        (A),
    .CLKCIA   (CLKCIA),
    .nCIACS0  (nCIACS0),
    .nCIACS1  (nCIACS1),
    .TA_REQ   (TA_REQ),
    .TEA_REQ  (TEA_REQ),
    .CIA_BUSY (CIA_BUSY)
  );

  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  // CLK7 stand-in: 3 CLK40 cycles high, 3 low, changing on the falling CLK40 edge.
  initial begin
    CLK7  = 1'b0;
    c7cnt = 0;
  end
  always @(negedge CLK40) begin
    if (clk7_run) begin
      if (c7cnt == 2) begin
        c7cnt <= 0;
        CLK7  <= ~CLK7;
      end else begin
        c7cnt <= c7cnt + 1;
      end
    end else begin
      c7cnt <= 0;
      CLK7  <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge CLK40);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(input string tag);
    logic prev;
    bit   found;
    prev  = CLKCIA;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (!prev && CLKCIA) found = 1;
      prev = CLKCIA;
    end
    check({tag, "_erise"}, int'(found), 1);
  endtask

  task automatic run_len(input logic level, output int n);
    n = 0;
    while (CLKCIA === level && n < 200) begin
      n++;
      step();
    end
  endtask

  // One CIA access; lead = cycles after an E rise before TS is driven.
  task automatic access(input string tag, input logic [1:0] a, input logic rnw,
                        input int lead, input bit abort, input int exp_falls);
    exp_t e;
    logic prev_clk, prev_cs;
    bit   started, done, aligned, ta_rise;
    int   falls, len0, len1, ta, busy_at_ta, busy_after;

    wait_rise(tag);
    repeat (lead) step();
    TS = 1'b1; CIA_SPACE = 1'b1; A = a; RnW = rnw;
    e.e_falls   = exp_falls;
    e.len0      = a[0] ? 0 : 60;
    e.len1      = a[1] ? 0 : 60;
    e.ta_pulses = 1;
    sb.push_back(e);

    prev_clk = CLKCIA; prev_cs = 1'b0;
    started = 0; done = 0; aligned = 0; ta_rise = 0;
    falls = 0; len0 = 0; len1 = 0; ta = 0; busy_at_ta = 0; busy_after = 1;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (abort && i == 1) TS = 1'b0;
      if (!started && prev_clk && !CLKCIA) falls++;
      if (!started && (!nCIACS0 || !nCIACS1)) begin
        started = 1;
        aligned = prev_clk && !CLKCIA;
      end
      if (!nCIACS0) len0++;
      if (!nCIACS1) len1++;
      if (TA_REQ) begin
        ta++;
        ta_rise    = prev_cs && nCIACS0 && nCIACS1;
        busy_at_ta = int'(CIA_BUSY);
        TS = 1'b0; CIA_SPACE = 1'b0;
        done = 1;
      end
      prev_clk = CLKCIA;
      prev_cs  = !nCIACS0 || !nCIACS1;
    end
    TS = 1'b0; CIA_SPACE = 1'b0;
    step();
    busy_after = int'(CIA_BUSY);
    if (TA_REQ) ta++;
    repeat (10) begin
      step();
      if (TA_REQ) ta++;
      if (!nCIACS0) len0++;
      if (!nCIACS1) len1++;
    end

    e = sb.pop_front();
    check({tag, "_efalls"},     falls,          e.e_falls);
    check({tag, "_cs0_len"},    len0,           e.len0);
    check({tag, "_cs1_len"},    len1,           e.len1);
    check({tag, "_ta_pulses"},  ta,             e.ta_pulses);
    check({tag, "_cs_aligned"}, int'(aligned),  1);
    check({tag, "_ta_at_rise"}, int'(ta_rise),  1);
    check({tag, "_busy_at_ta"}, busy_at_ta,     1);
    check({tag, "_busy_after"}, busy_after,     0);
  endtask

  initial begin
    int   n, bad_busy, bad_cs, bad_ta, ta, tea, first_busy, tea_at, busy_low;
    bit   found;

    n_checks = 0; n_pass = 0; n_fail = 0;
    nRESET = 1'b0; TS = 1'b0; CIA_SPACE = 1'b0; RnW = 1'b1; A = 2'b11;
    clk7_run = 1'b1;

    // Reset values
    repeat (5) step();
    check("rst_clkcia", int'(CLKCIA),   0);
    check("rst_ncs0",   int'(nCIACS0),  1);
    check("rst_ncs1",   int'(nCIACS1),  1);
    check("rst_ta",     int'(TA_REQ),   0);
    check("rst_tea",    int'(TEA_REQ),  0);
    check("rst_busy",   int'(CIA_BUSY), 0);
    nRESET = 1'b1;

    // E clock shape: 24 cycles high, 36 low, twice over
    wait_rise("eclk");
    for (int p = 0; p < 2; p++) begin
      run_len(1'b1, n);
      check("eclk_high", n, 24);
      run_len(1'b0, n);
      check("eclk_low", n, 36);
    end

    // CIA0 read mid E-high; both-selected write coincident with ewrap; CIA1 with TS aborted in ARM
    access("cia0_rd", 2'b10, 1'b1, 10, 1'b0, 1);
    access("both_wr", 2'b00, 1'b0, 23, 1'b0, 2);
    access("abort",   2'b01, 1'b1, 10, 1'b1, 1);

    // Non-CIA access must be ignored
    TS = 1'b1; CIA_SPACE = 1'b0; A = 2'b00;
    bad_busy = 0; bad_cs = 0; bad_ta = 0;
    repeat (100) begin
      step();
      if (CIA_BUSY) bad_busy++;
      if (!nCIACS0 || !nCIACS1) bad_cs++;
      if (TA_REQ) bad_ta++;
    end
    check("noncia_busy", bad_busy, 0);
    check("noncia_cs",   bad_cs,   0);
    check("noncia_ta",   bad_ta,   0);
    TS = 1'b0;
    step();

    // Reset 20 cycles into the strobe phase
    wait_rise("rstmid");
    repeat (10) step();
    TS = 1'b1; CIA_SPACE = 1'b1; A = 2'b00;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (!nCIACS0) found = 1;
    end
    check("rstmid_cs_seen", int'(found), 1);
    repeat (20) step();
    nRESET = 1'b0;
    step();
    check("rstmid_ncs0", int'(nCIACS0),  1);
    check("rstmid_ncs1", int'(nCIACS1),  1);
    check("rstmid_busy", int'(CIA_BUSY), 0);
    check("rstmid_ta",   int'(TA_REQ),   0);
    nRESET = 1'b1; TS = 1'b0; CIA_SPACE = 1'b0;
    ta = 0;
    repeat (150) begin
      step();
      if (TA_REQ) ta++;
    end
    check("rstmid_no_ta", ta, 0);

    // CLK7 stopped: access never sees an E falling edge
    clk7_run = 1'b0;
    repeat (10) step();
    TS = 1'b1; CIA_SPACE = 1'b1; A = 2'b10; RnW = 1'b1;
    first_busy = -1; tea = 0; tea_at = -1; ta = 0; busy_low = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (CIA_BUSY && first_busy < 0) first_busy = i;
      if (TEA_REQ) begin
        tea++;
        tea_at = i;
        TS = 1'b0; CIA_SPACE = 1'b0;
      end
      if (TA_REQ) ta++;
      if (first_busy >= 0 && !CIA_BUSY) busy_low++;
    end
`ifdef CIA_TIMEOUT_EN
    check("wd_tea_pulses", tea, 1);
    check("wd_tea_delay",  tea_at - first_busy, 64);
    check("wd_no_ta",      ta, 0);
    check("wd_idle_after", int'(CIA_BUSY), 0);
`else
    check("stall_busy_start", first_busy, 0);
    check("stall_busy_held",  busy_low, 0);
    check("stall_no_tea",     tea, 0);
    check("stall_no_ta",      ta, 0);
`endif
    TS = 1'b0; CIA_SPACE = 1'b0;
    nRESET = 1'b0;
    step();
    nRESET = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cia_cycle_sequencer.md
Name:
cia_cycle_sequencer

Overview:
- Sequences 68040 accesses to the two 8520 CIAs in the CLK40 domain.
- Generates the CIA E clock (CLKCIA) from a synchronised CLK7.
- Aligns each CIA access to a full E period and drives the CIA chip selects.
- Requests transfer ack at E-cycle end. Sits beside address decode / transfer-ack logic, which supplies TS and CIA_SPACE and turns TA_REQ into open-drain nTA.

Parameters:
- E_LOW_TICKS, 6, CLK7 rising edges per E low phase.
- E_HIGH_TICKS, 4, CLK7 rising edges per E high phase.
- TIMEOUT_CYCLES, 2048, CLK40 cycles before an unfinished access aborts (used only with the optional feature).

Ports:
- CLK40  in  1  system clock; all flops on rising edge.
- nRESET  in  1  synchronous active-low reset, sampled on CLK40 rising edge.
- CLK7  in  1  7 MHz clock, asynchronous to CLK40; treated as data.
- TS  in  1  latched transfer start, high from 040 _TS until nTA.
- CIA_SPACE  in  1  decoded CIA address window (0xBFxxxx), valid while TS high.
- RnW  in  1  040 read/write, valid while TS high.
- A  in  2  A[13:12]; A12 low selects CIA0, A13 low selects CIA1.
- CLKCIA  out  1  CIA E clock, registered.
- nCIACS0  out  1  CIA0 chip select, active low, registered.
- nCIACS1  out  1  CIA1 chip select, active low, registered.
- TA_REQ  out  1  one-cycle transfer-ack request, active high.
- TEA_REQ  out  1  one-cycle error-ack request, active high (optional feature only; else tied 0).
- CIA_BUSY  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (nRESET low at a CLK40 edge): ecnt=0, CLKCIA=0, nCIACS0=nCIACS1=1, TA_REQ=0, TEA_REQ=0, state=IDLE, sync chain=0.
- Sync: two-flop synchroniser on CLK7, plus a third flop for edge detect.
  - tick = s2 & !s3, exactly one CLK40 cycle per CLK7 rising edge.
  - Latency from CLK7 edge to tick: 2–3 CLK40 cycles.
- E counter: ecnt counts 0..E_LOW_TICKS+E_HIGH_TICKS-1.
  - Increments on tick; wraps to 0 on tick at the last value.
  - Unsigned; width is clog2 of the period.
  - CLKCIA registered as (ecnt_next >= E_LOW_TICKS). Defaults give 6 low / 4 high ticks.
  - Free-running, independent of the FSM.
- ewrap = tick & (ecnt == last); marks the E falling edge.
- FSM states: IDLE, ARM, STROBE, DONE.
  - IDLE: if TS & CIA_SPACE & !TA_REQ, go to ARM and latch cs0=!A[12], cs1=!A[13]. Both low means both selected (legal).
  - ARM: wait for ewrap, then go to STROBE and assert the latched chip selects on the same edge. Even if TS rose in the same cycle as an ewrap, the block waits for the next ewrap, so CS always spans one full E period.
  - STROBE: chip selects held low. On the next ewrap, go to DONE: deassert both CS and pulse TA_REQ=1 for exactly that one cycle.
  - DONE: TA_REQ=0; unconditionally go to IDLE. This gives one recovery cycle before a new TS can be accepted (TS clears via nTA).
- RnW is not used for timing: read and write sequences are identical. CIA data is valid at the E falling edge, and TA follows in the same cycle.
- TS, CIA_SPACE and A changes after ARM are ignored.
- TS low while in ARM or STROBE (bus abort): the access completes anyway; no back-out.
- CIA_BUSY = (state != IDLE).
- Mid-operation reset: next CLK40 edge forces the reset values. No TA_REQ is emitted, and CS deasserts immediately.
- Total access latency: between 1 and 2 E periods plus 1 CLK40 cycle.

Optional Feature:
- Macro: CIA_TIMEOUT_EN.
- Defined:
  - An 11+ bit watchdog clears in IDLE and counts every CLK40 cycle in ARM or STROBE.
  - On reaching TIMEOUT_CYCLES-1 (for example, CLK7 stopped), go to DONE with TEA_REQ=1 for one cycle and TA_REQ=0; CS deasserts.
  - ewrap takes priority over timeout if both occur in the same cycle.
- Not defined: no watchdog logic; TEA_REQ tied 0; the FSM waits for ewrap indefinitely.

Test Plan:
- Reset/E clock: CLK7 period = 6 CLK40 cycles (3 high / 3 low); release nRESET.
  → CLKCIA is 0 for 36 CLK40 cycles, then 1 for 24 cycles, repeating; period = 60 cycles. Outputs are at reset values while nRESET is low.
- CIA0 read: TS=1, CIA_SPACE=1, A=2'b10, RnW=1, asserted mid E-high.
  → nCIACS0 falls on the next ewrap and stays low exactly 60 cycles. nCIACS1 stays 1. TA_REQ is high for 1 cycle coincident with the CS rise. CIA_BUSY returns low 1 cycle later.
- Both selected write: A=2'b00, RnW=0, TS coincident with an ewrap cycle.
  → No assertion on that ewrap. Both CS go low together on the following ewrap, for 60 cycles, then a single TA_REQ pulse.
- Reset mid-STROBE: drive nRESET low 20 cycles into CS-low.
  → On the next edge both CS=1, state IDLE, and no TA_REQ ever pulses.
- Non-CIA / abort: TS=1 with CIA_SPACE=0 → FSM stays IDLE, no CS, no TA_REQ. Separately, TS dropped during ARM → cycle still completes with one TA_REQ.
- With CIA_TIMEOUT_EN, TIMEOUT_CYCLES=64: hold CLK7 low, issue a CIA access.
  → After 64 cycles in ARM, TEA_REQ pulses for 1 cycle, TA_REQ stays 0, and the FSM returns to IDLE. Without the macro, CIA_BUSY stays 1.
